pe_loop_addr_gen: RTL and testbench
===================================

// Module: pe_loop_addr_gen
// PURPOSE
//  Parametrised N-deep loop-nest sequencer with strided address generation for PE scratchpads.
//  Walks a configurable loop nest and emits one beat per index tuple on a rdy/ack port.
//  Each beat carries the index vector, per-level end/wrap flags and a pad address.
//  Replaces the fixed per-pad loop counters and address counters in the PE datapath controller.
// PARAMETERS
//  NDIM   5  number of loop levels; level 0 is innermost
//  IDXW   6  width of each loop index and size field
//  ADDRW  8  pad address width; all address arithmetic is modulo 2^ADDRW
// PORTS
//  i_clk        in   1           clock
//  i_rst        in   1           asynchronous reset, active-high
//  i_start      in   1           start pulse; honoured only in IDLE
//  i_stall      in   1           hold beat generation
//  i_abort      in   1           abandon the current walk
//  i_size       in   NDIM*IDXW   per-level trip count; 0 is treated as 1
//  i_stride     in   NDIM*ADDRW  per-level address increment
//  i_base       in   ADDRW       address of the first beat
//  o_rdy        out  1           beat valid
//  i_ack        in   1           consumer accepts the beat
//  o_idx        out  NDIM*IDXW   current 0-based index per level
//  o_end        out  NDIM        per level: o_idx[k] == size[k]-1
//  o_wrap       out  NDIM        per level: this beat wraps level k (o_end[k..0] all set)
//  o_last       out  1           final beat of the nest (&o_end)
//  o_addr       out  ADDRW       base + sum(idx[k]*stride[k]) mod 2^ADDRW
//  o_busy       out  1           state is not IDLE
//  o_done       out  1           one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: state IDLE; all idx 0; o_addr 0; o_rdy, o_busy and o_done 0.
//   o_end, o_wrap and o_last are 0 whenever state is not RUN/STALL.
//  FSM states: IDLE, LOAD, RUN, STALL, DONE.
//   IDLE -> LOAD on i_start.
//   LOAD is 1 cycle: latches size/stride/base (size 0 -> 1), clears idx, sets addr = base.
//   LOAD -> RUN.
//   RUN -> STALL when i_stall. STALL -> RUN when !i_stall.
//   RUN -> DONE on a transfer with o_last set.
//   DONE is 1 cycle with o_done=1, then -> IDLE.
//  Start latency: first o_rdy is 2 cycles after i_start is sampled.
//  i_abort in any state -> IDLE next cycle; idx and addr are cleared; no o_done. i_abort has priority over every other input.
//  i_start outside IDLE is ignored. Config inputs are sampled only in LOAD.
//  Handshake: o_rdy = (state==RUN) && !i_stall, combinational on i_stall.
//   A transfer is o_rdy && i_ack. Beat fields are stable while o_rdy && !i_ack.
//   o_rdy may be withdrawn by i_stall without an ack; the beat is not consumed.
//  Advance on a transfer, registered, so the next beat appears the following cycle:
//   Odometer order: lowest k with !o_end[k] increments; all levels below k reset to 0.
//   Address is incremental, with no multiplier: addr_next = addr + stride[k] - sum_{j<k}(idx[j]*stride[j]).
//   The subtracted span per level is held in registered accumulators, updated on each transfer.
//  Back-to-back transfers sustain 1 beat per cycle.
//  Total beats = product of effective sizes.
//  Single-beat nest (all sizes <=1): first beat has o_last=1 and o_wrap all 1.
// TESTING
//  NDIM=2, size={3,2}, stride={1,4}, base=0x10, i_ack=1
//   -> addr 10,11,12,14,15,16; o_last on beat 6; o_done 1 cycle later.
//  Same config, i_stall high for 3 cycles mid-walk
//   -> o_rdy low for exactly those cycles; no beat lost or repeated.
//  i_ack held low for 4 cycles on beat 2
//   -> o_idx and o_addr stable for all 4 cycles; walk then resumes.
//  base=0xFE, stride={1}, size={4}
//   -> addr FE,FF,00,01 (modulo wrap); o_wrap[0] only on beat 4.
//  i_abort on beat 3, then i_start
//   -> no o_done from the aborted walk; new walk restarts at base with idx 0.
//  All sizes 0
//   -> exactly 1 beat with o_last=1; i_start while busy is ignored.

Source files
------------

// File: rtl/pe_loop_addr_gen.sv
// pe_loop_addr_gen: loop-nest sequencer emitting index tuples and strided pad addresses on a rdy/ack port
module pe_loop_addr_gen #(
    parameter int NDIM  = 5,
    parameter int IDXW  = 6,
    parameter int ADDRW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stall,
    input  logic                  i_abort,
    input  logic [NDIM*IDXW-1:0]  i_size,
    input  logic [NDIM*ADDRW-1:0] i_stride,
    input  logic [ADDRW-1:0]      i_base,
    output logic                  o_rdy,
    input  logic                  i_ack,
    output logic [NDIM*IDXW-1:0]  o_idx,
    output logic [NDIM-1:0]       o_end,
    output logic [NDIM-1:0]       o_wrap,
    output logic                  o_last,
    output logic [ADDRW-1:0]      o_addr,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STALL, S_DONE} state_t;
    state_t           r_state, w_next;
    logic [IDXW-1:0]  r_idx [NDIM];
    logic [IDXW-1:0]  r_size [NDIM];
    logic [ADDRW-1:0] r_stride [NDIM];
    logic [ADDRW-1:0] r_span [NDIM];
    logic [ADDRW-1:0] r_addr, w_addr_next;
    logic [NDIM-1:0]  w_endr, w_inc, w_wrapr;
    logic             w_carry, w_active, w_xfer;

    // odometer carry chain: level k increments when every lower level is at its end; address moves incrementally by stride minus the spans of wrapping levels
    always_comb begin
        w_carry     = 1'b1;
        w_addr_next = r_addr;
        for (int k = 0; k < NDIM; k++) begin
            w_endr[k]   = r_idx[k] == r_size[k] - IDXW'(1);
            w_inc[k]    = w_carry && !w_endr[k];
            w_wrapr[k]  = w_carry && w_endr[k];
            w_carry     = w_wrapr[k];
            w_addr_next = w_addr_next + (w_inc[k] ? r_stride[k] : '0) - (w_wrapr[k] ? r_span[k] : '0);
        end
    end

    assign w_active = (r_state == S_RUN) || (r_state == S_STALL);
    assign o_rdy    = (r_state == S_RUN) && !i_stall;
    assign w_xfer   = o_rdy && i_ack && !i_abort;
    assign o_end    = w_active ? w_endr : '0;
    assign o_wrap   = w_active ? w_wrapr : '0;
    assign o_last   = w_active && (&w_endr);
    assign o_addr   = r_addr;
    assign o_busy   = r_state != S_IDLE;
    assign o_done   = r_state == S_DONE;

    for (genvar g = 0; g < NDIM; g++) begin : g_idx
        assign o_idx[g*IDXW +: IDXW] = r_idx[g];
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic; abort overrides everything
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   w_next = (w_xfer && o_last) ? S_DONE : (i_stall ? S_STALL : S_RUN);
            S_STALL: w_next = i_stall ? S_STALL : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    // datapath: config capture in LOAD, odometer/address/span advance on each transfer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
            for (int k = 0; k < NDIM; k++) begin
                r_idx[k]    <= '0;
                r_span[k]   <= '0;
                r_size[k]   <= '0;
                r_stride[k] <= '0;
            end
        end else if (i_abort) begin
            r_addr <= '0;
            for (int k = 0; k < NDIM; k++) begin
                r_idx[k]  <= '0;
                r_span[k] <= '0;
            end
        end else if (r_state == S_LOAD) begin
            r_addr <= i_base;
            for (int k = 0; k < NDIM; k++) begin
                r_idx[k]    <= '0;
                r_span[k]   <= '0;
                r_size[k]   <= (i_size[k*IDXW +: IDXW] == '0) ? IDXW'(1) : i_size[k*IDXW +: IDXW];
                r_stride[k] <= i_stride[k*ADDRW +: ADDRW];
            end
        end else if (w_xfer) begin
            r_addr <= w_addr_next;
            for (int k = 0; k < NDIM; k++) begin
                r_idx[k]  <= w_inc[k] ? r_idx[k] + IDXW'(1) : (w_wrapr[k] ? '0 : r_idx[k]);
                r_span[k] <= w_inc[k] ? r_span[k] + r_stride[k] : (w_wrapr[k] ? '0 : r_span[k]);
            end
        end
    end
endmodule

// File: tb/tb_pe_loop_addr_gen.sv
// tb_pe_loop_addr_gen: scoreboard bench for the loop-nest address sequencer
module tb_pe_loop_addr_gen;
    localparam int NDIM = 5, IDXW = 6, ADDRW = 8;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0, abort = 1'b0, ack = 1'b0;
    logic [NDIM*IDXW-1:0]  size = '0;
    logic [NDIM*ADDRW-1:0] stride = '0;
    logic [ADDRW-1:0]      base = '0;
    logic                  o_rdy, o_last, o_busy, o_done;
    logic [NDIM*IDXW-1:0]  o_idx;
    logic [NDIM-1:0]       o_end, o_wrap;
    logic [ADDRW-1:0]      o_addr;

    typedef struct {
        logic [NDIM*IDXW-1:0] idx;
        logic [ADDRW-1:0]     addr;
        logic [NDIM-1:0]      wrap;
        logic                 last;
    } beat_t;

    beat_t q[$];
    beat_t b;
    int sz[NDIM], st[NDIM], bs;
    int tests = 0, fails = 0;

    pe_loop_addr_gen #(.NDIM(NDIM), .IDXW(IDXW), .ADDRW(ADDRW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_abort(abort),
        .i_size(size), .i_stride(stride), .i_base(base), .o_rdy(o_rdy), .i_ack(ack),
        .o_idx(o_idx), .o_end(o_end), .o_wrap(o_wrap), .o_last(o_last), .o_addr(o_addr),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // levels 2..NDIM-1 get size 0 (treated as 1) and a stride that must never contribute
    task automatic cfg(input int s0, input int s1, input int t0, input int t1, input int b0);
        sz[0] = s0; sz[1] = s1; st[0] = t0; st[1] = t1; bs = b0;
        for (int k = 2; k < NDIM; k++) begin
            sz[k] = 0;
            st[k] = 7;
        end
        for (int k = 0; k < NDIM; k++) begin
            size[k*IDXW +: IDXW]     = IDXW'(sz[k]);
            stride[k*ADDRW +: ADDRW] = ADDRW'(st[k]);
        end
        base = ADDRW'(bs);
    endtask

    // reference walk: decompose beat number into mixed-radix indices, address by multiplication
    task automatic push_model();
        int e[NDIM];
        int id[NDIM];
        int tot, rem, a;
        logic w;
        beat_t nb;
        tot = 1;
        for (int k = 0; k < NDIM; k++) begin
            e[k] = (sz[k] == 0) ? 1 : sz[k];
            tot *= e[k];
        end
        for (int t = 0; t < tot; t++) begin
            rem = t;
            a   = bs;
            w   = 1'b1;
            for (int k = 0; k < NDIM; k++) begin
                id[k] = rem % e[k];
                rem   = rem / e[k];
                a    += id[k] * st[k];
                nb.idx[k*IDXW +: IDXW] = id[k][IDXW-1:0];
                w = w && (id[k] == e[k] - 1);
                nb.wrap[k] = w;
            end
            nb.addr = a[ADDRW-1:0];
            nb.last = (t == tot - 1);
            q.push_back(nb);
        end
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        tests++;
        if (o_rdy !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b want 0 0 0", o_rdy, o_busy, o_done);
        end
        tests++;
        if (o_idx !== '0 || o_addr !== '0) begin
            fails++;
            $display("FAIL reset_data got idx=%h addr=%h want 0 0", o_idx, o_addr);
        end
        tests++;
        if (o_end !== '0 || o_wrap !== '0 || o_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got end=%b wrap=%b last=%b want 0 0 0", o_end, o_wrap, o_last);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc = 0;
        cfg(3, 2, 1, 4, 8'h10);
        push_model();
        ack = 1'b1;
        kick();
        @(negedge clk);
        tests++;
        if (o_rdy !== 1'b0 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_load got rdy=%b busy=%b want 0 1", o_rdy, o_busy);
        end
        @(posedge clk); #1;
        base = 8'h00;
        size = '1;
        while (q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (o_rdy && ack) begin
                b = q.pop_front();
                tests++;
                if (o_idx !== b.idx || o_addr !== b.addr || o_wrap !== b.wrap || o_last !== b.last) begin
                    fails++;
                    $display("FAIL basic_beat got idx=%h addr=%h wrap=%b last=%b want idx=%h addr=%h wrap=%b last=%b",
                             o_idx, o_addr, o_wrap, o_last, b.idx, b.addr, b.wrap, b.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (q.size() != 0 || cyc != 6) begin
            fails++;
            $display("FAIL basic_rate got left=%0d cycles=%0d want 0 6", q.size(), cyc);
        end
        @(negedge clk);
        tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_done got done=%b busy=%b want 1 1", o_done, o_busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle got done=%b busy=%b want 0 0", o_done, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int cyc = 0;
        cfg(3, 2, 1, 4, 8'h10);
        push_model();
        ack = 1'b1;
        kick();
        @(posedge clk); #1;
        while (q.size() > 0 && cyc < 40) begin
            stall = (cyc >= 2 && cyc < 5);
            @(negedge clk);
            if (stall) begin
                tests++;
                if (o_rdy !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_rdy cycle %0d got rdy=%b want 0", cyc, o_rdy);
                end
            end
            if (o_rdy && ack) begin
                b = q.pop_front();
                tests++;
                if (o_idx !== b.idx || o_addr !== b.addr || o_wrap !== b.wrap || o_last !== b.last) begin
                    fails++;
                    $display("FAIL stall_beat got idx=%h addr=%h wrap=%b last=%b want idx=%h addr=%h wrap=%b last=%b",
                             o_idx, o_addr, o_wrap, o_last, b.idx, b.addr, b.wrap, b.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0;
        @(negedge clk);
        tests++;
        if (q.size() != 0 || o_done !== 1'b1) begin
            fails++;
            $display("FAIL stall_done got left=%0d done=%b want 0 1", q.size(), o_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ack_hold();
        int cyc = 0, n = 0, hold = 0;
        cfg(3, 2, 1, 4, 8'h10);
        push_model();
        kick();
        @(posedge clk); #1;
        while (q.size() > 0 && cyc < 40) begin
            ack = !(n == 1 && hold < 4);
            @(negedge clk);
            if (o_rdy && !ack) begin
                tests++;
                if (o_idx !== q[0].idx || o_addr !== q[0].addr) begin
                    fails++;
                    $display("FAIL hold_stable got idx=%h addr=%h want idx=%h addr=%h", o_idx, o_addr, q[0].idx, q[0].addr);
                end
                hold++;
            end
            if (o_rdy && ack) begin
                b = q.pop_front();
                n++;
                tests++;
                if (o_idx !== b.idx || o_addr !== b.addr || o_wrap !== b.wrap || o_last !== b.last) begin
                    fails++;
                    $display("FAIL hold_beat got idx=%h addr=%h wrap=%b last=%b want idx=%h addr=%h wrap=%b last=%b",
                             o_idx, o_addr, o_wrap, o_last, b.idx, b.addr, b.wrap, b.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        ack = 1'b1;
        @(negedge clk);
        tests++;
        if (q.size() != 0 || hold != 4 || o_done !== 1'b1) begin
            fails++;
            $display("FAIL hold_done got left=%0d held=%0d done=%b want 0 4 1", q.size(), hold, o_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int cyc = 0;
        cfg(4, 0, 1, 9, 8'hFE);
        push_model();
        ack = 1'b1;
        kick();
        @(posedge clk); #1;
        while (q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            if (o_rdy && ack) begin
                b = q.pop_front();
                tests++;
                if (o_idx !== b.idx || o_addr !== b.addr || o_wrap !== b.wrap || o_last !== b.last) begin
                    fails++;
                    $display("FAIL wrap_beat got idx=%h addr=%h wrap=%b last=%b want idx=%h addr=%h wrap=%b last=%b",
                             o_idx, o_addr, o_wrap, o_last, b.idx, b.addr, b.wrap, b.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        tests++;
        if (q.size() != 0 || o_done !== 1'b1) begin
            fails++;
            $display("FAIL wrap_done got left=%0d done=%b want 0 1", q.size(), o_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int cyc = 0, n = 0, dones = 0;
        cfg(3, 2, 1, 4, 8'h10);
        push_model();
        ack = 1'b1;
        kick();
        @(posedge clk); #1;
        while (n < 2 && cyc < 20) begin
            @(negedge clk);
            if (o_rdy && ack) begin
                b = q.pop_front();
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_idx !== '0 || o_addr !== '0 || o_rdy !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear got busy=%b idx=%h addr=%h rdy=%b want 0 0 0 0", o_busy, o_idx, o_addr, o_rdy);
        end
        for (int i = 0; i < 3; i++) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL abort_nodone got %0d done pulses want 0", dones);
        end
        @(posedge clk); #1;
        push_model();
        kick();
        @(posedge clk); #1;
        cyc = 0;
        while (q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (o_rdy && ack) begin
                b = q.pop_front();
                tests++;
                if (o_idx !== b.idx || o_addr !== b.addr || o_wrap !== b.wrap || o_last !== b.last) begin
                    fails++;
                    $display("FAIL abort_restart got idx=%h addr=%h wrap=%b last=%b want idx=%h addr=%h wrap=%b last=%b",
                             o_idx, o_addr, o_wrap, o_last, b.idx, b.addr, b.wrap, b.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        tests++;
        if (q.size() != 0 || o_done !== 1'b1) begin
            fails++;
            $display("FAIL abort_done got left=%0d done=%b want 0 1", q.size(), o_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        cfg(0, 0, 3, 5, 8'h33);
        push_model();
        ack = 1'b0;
        kick();
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        tests++;
        if (o_rdy !== 1'b1 || o_last !== 1'b1 || o_end !== '1 || o_wrap !== '1) begin
            fails++;
            $display("FAIL single_flags got rdy=%b last=%b end=%b wrap=%b want 1 1 11111 11111", o_rdy, o_last, o_end, o_wrap);
        end
        @(posedge clk); #1;
        ack = 1'b1;
        @(negedge clk);
        if (o_rdy && ack && q.size() > 0) begin
            b = q.pop_front();
            tests++;
            if (o_idx !== b.idx || o_addr !== b.addr || o_wrap !== b.wrap || o_last !== b.last) begin
                fails++;
                $display("FAIL single_beat got idx=%h addr=%h wrap=%b last=%b want idx=%h addr=%h wrap=%b last=%b",
                         o_idx, o_addr, o_wrap, o_last, b.idx, b.addr, b.wrap, b.last);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (q.size() != 0 || o_done !== 1'b1) begin
            fails++;
            $display("FAIL single_done got left=%0d done=%b want 0 1", q.size(), o_done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_busy || o_done) busy_cnt++;
        end
        tests++;
        if (busy_cnt != 0) begin
            fails++;
            $display("FAIL single_ignore_start got %0d busy cycles want 0", busy_cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ack_hold();
        test_wrap();
        test_abort();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
